mem_fill_loader: RTL

Sequential memory writer for the lab memory subsystem. It is the load side of the memory dump path: where the dump path sweeps addresses out of memory, this block takes a stream of words over a valid/ready handshake and writes them into memory at consecutive addresses. It starts at a programmable base and writes a programmable word count. It sits between the host/UART receive path and the data-memory write port.

---
 rtl/mem_fill_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_fill_loader.sv
// Streams words from a valid/ready source into memory at consecutive
// addresses, starting at a latched base, for a latched word count.
module mem_fill_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              accept;

  // abort gates ready combinationally so an aborted cycle never consumes
  assign in_ready = (state_q == LOAD) && !abort;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= base_addr;
            rem_q   <= length;
            cnt_q   <= '0;
            state_q <= (length == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (accept) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= in_data;
            ptr_q   <= ptr_q + ONE;
            rem_q   <= rem_q - ONE;
            cnt_q   <= cnt_q + ONE;
            if (rem_q == ONE) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign word_count = cnt_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
